// File: rtl/median_avalon_csr.sv
// Avalon-MM front end for the median filter: packs host words into a pixel row,
// hands it to the core, captures the filtered row and drains it word by word.
module median_avalon_csr #(
  parameter int ROW_PIX = 256,
  parameter int PIX_W   = 8,
  parameter int LINES   = 3,
  parameter int BUS_W   = 32,
  localparam int ROW_BITS = ROW_PIX * PIX_W * LINES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ChipSelect,
  input  logic [1:0]          Address,
  input  logic                Write,
  input  logic                Read,
  input  logic [BUS_W-1:0]    WriteData,
  output logic [BUS_W-1:0]    ReadData,
  output logic                irq,
  output logic [ROW_BITS-1:0] row_in,
  output logic                in_valid,
  input  logic                in_ready,
  input  logic [ROW_BITS-1:0] row_out,
  input  logic                out_valid
);

  localparam int WORDS = ROW_BITS / BUS_W;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int IW    = $clog2(ROW_BITS);

  if (ROW_BITS % BUS_W != 0) begin : g_bad_width
    $error("median_avalon_csr: ROW_BITS must be a multiple of BUS_W");
  end
  if (WORDS > 65535) begin : g_bad_words
    $error("median_avalon_csr: WORDS must not exceed 65535");
  end

  typedef enum logic {FILL, PEND} state_t;

  state_t              state;
  logic [CW-1:0]       wr_cnt;
  logic [CW-1:0]       rd_idx;
  logic [ROW_BITS-1:0] out_buf;
  logic                out_full;
  logic                overflow;
  logic                overrun;
  logic                underflow;
  logic                irq_en;

  logic                wr_data, wr_stat, wr_ctrl, rd_en, rd_out, soft_clear, last_rd, in_pend;
  logic [IW-1:0]       wr_base, rd_base;
  logic [BUS_W-1:0]    rd_word;
  logic [31:0]         status_word;

  always_comb begin
    wr_data     = ChipSelect & Write & (Address == 2'd0);
    wr_stat     = ChipSelect & Write & (Address == 2'd2);
    wr_ctrl     = ChipSelect & Write & (Address == 2'd3);
    rd_en       = ChipSelect & Read;
    rd_out      = rd_en & (Address == 2'd1);
    soft_clear  = wr_ctrl & WriteData[1];
    last_rd     = rd_out & out_full & (rd_idx == CW'(WORDS - 1));
    in_pend     = (state == PEND);
    // word k lives at the MS end minus k words, so the first word is most significant
    wr_base     = IW'(ROW_BITS - 1 - int'(wr_cnt) * BUS_W);
    rd_base     = IW'(ROW_BITS - 1 - int'(rd_idx) * BUS_W);
    rd_word     = out_buf[rd_base -: BUS_W];
    status_word = {16'(wr_cnt), 11'd0, underflow, overrun, overflow, out_full, in_pend};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_idx    <= '0;
      row_in    <= '0;
      out_buf   <= '0;
      in_valid  <= 1'b0;
      out_full  <= 1'b0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
      underflow <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      ReadData  <= '0;
    end else begin
      if (rd_en) begin
        case (Address)
          2'd1:    ReadData <= out_full ? rd_word : '0;
          2'd2:    ReadData <= BUS_W'(status_word);
          2'd3:    ReadData <= BUS_W'(irq_en);
          default: ReadData <= '0;
        endcase
      end

      irq <= irq_en & (out_full | overflow | overrun | underflow);

      if (wr_ctrl) irq_en <= WriteData[0];

      if (soft_clear) begin
        state     <= FILL;
        wr_cnt    <= '0;
        rd_idx    <= '0;
        in_valid  <= 1'b0;
        out_full  <= 1'b0;
        overflow  <= 1'b0;
        overrun   <= 1'b0;
        underflow <= 1'b0;
      end else begin
        case (state)
          FILL: if (wr_data) begin
            row_in[wr_base -: BUS_W] <= WriteData;
            if (wr_cnt == CW'(WORDS - 1)) begin
              wr_cnt   <= '0;
              in_valid <= 1'b1;
              state    <= PEND;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
          PEND: if (in_ready) begin
            in_valid <= 1'b0;
            state    <= FILL;
          end
          default: state <= FILL;
        endcase

        // clears are applied first so a same-cycle set overrides them
        if (wr_stat) begin
          if (WriteData[2]) overflow  <= 1'b0;
          if (WriteData[3]) overrun   <= 1'b0;
          if (WriteData[4]) underflow <= 1'b0;
        end
        if (wr_data && state == PEND) overflow <= 1'b1;

        if (rd_out) begin
          if (out_full) begin
            rd_idx <= rd_idx + 1'b1;
            if (last_rd) out_full <= 1'b0;
          end else begin
            underflow <= 1'b1;
          end
        end

        if (out_valid) begin
          if (!out_full || last_rd) begin
            out_buf  <= row_out;
            out_full <= 1'b1;
            rd_idx   <= '0;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_median_avalon_csr.sv
// Bench for median_avalon_csr: a 3-word instance for the control scenarios and a
// default-sized instance for the full 192-word row and loopback.
module tb_median_avalon_csr;

  localparam int SB = 96;
  localparam int DB = 6144;
  localparam int DW = 192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs_s, cs_d, wr, rd;
  logic [1:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata_s, rdata_d;
  logic          irq_s, irq_d;
  logic [SB-1:0] row_in_s, row_out_s;
  logic [DB-1:0] row_in_d, row_out_d;
  logic          in_valid_s, in_valid_d, in_ready, out_valid_s, out_valid_d;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [31:0]   exp_q[$];
  logic [SB-1:0] row_q[$];

  always #5 clk = ~clk;

  median_avalon_csr #(.ROW_PIX(4), .PIX_W(8), .LINES(3), .BUS_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .ChipSelect(cs_s), .Address(addr), .Write(wr), .Read(rd),
    .WriteData(wdata), .ReadData(rdata_s), .irq(irq_s), .row_in(row_in_s),
    .in_valid(in_valid_s), .in_ready(in_ready), .row_out(row_out_s), .out_valid(out_valid_s)
  );

  median_avalon_csr dut_d (
    .clk(clk), .rst_n(rst_n), .ChipSelect(cs_d), .Address(addr), .Write(wr), .Read(rd),
    .WriteData(wdata), .ReadData(rdata_d), .irq(irq_d), .row_in(row_in_d),
    .in_valid(in_valid_d), .in_ready(in_ready), .row_out(row_out_d), .out_valid(out_valid_d)
  );

  task automatic bus_wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs_s = !sel; cs_d = sel; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs_s = 1'b0; cs_d = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input bit sel, input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cs_s = !sel; cs_d = sel; rd = 1'b1; addr = a;
    @(negedge clk);
    cs_s = 1'b0; cs_d = 1'b0; rd = 1'b0;
    d = sel ? rdata_d : rdata_s;
  endtask

  task automatic pulse_s(input logic [SB-1:0] r);
    @(negedge clk);
    row_out_s = r; out_valid_s = 1'b1;
    @(negedge clk);
    out_valid_s = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({rdata_s, irq_s, in_valid_s, row_in_s, rdata_d, irq_d, in_valid_d} !== '0 || row_in_d !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%h irq=%b in_valid=%b row_in=%h required all zero",
               rdata_s, irq_s, in_valid_s, row_in_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL reset_status: got %h required %h", d, e); end
    bus_rd(0, 3, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL reset_ctrl: got %h required %h", d, e); end
  endtask

  task automatic test_fill();
    logic [31:0]   d, e;
    logic [SB-1:0] r;
    in_ready = 1'b1;
    row_q.push_back(96'h111111112222222233333333);
    bus_wr(0, 0, 32'h11111111);
    bus_wr(0, 0, 32'h22222222);
    bus_wr(0, 0, 32'h33333333);
    r = row_q.pop_front();
    n_tests++;
    if (in_valid_s !== 1'b1 || row_in_s !== r) begin
      n_fail++;
      $display("FAIL fill_row: got in_valid=%b row=%h required 1 %h", in_valid_s, row_in_s, r);
    end
    @(negedge clk);
    n_tests++;
    if (in_valid_s !== 1'b0) begin
      n_fail++; $display("FAIL fill_valid_one_cycle: got %b required 0", in_valid_s);
    end
    exp_q.push_back(32'h0);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL fill_status: got %h required %h", d, e); end
  endtask

  task automatic test_backpressure();
    logic [31:0]   d, e;
    logic [SB-1:0] r;
    int            bad;
    in_ready = 1'b0;
    row_q.push_back(96'h111111112222222233333333);
    bus_wr(0, 0, 32'h11111111);
    bus_wr(0, 0, 32'h22222222);
    bus_wr(0, 0, 32'h33333333);
    r = row_q.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_valid_s !== 1'b1 || row_in_s !== r) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
    bus_wr(0, 0, 32'h44444444);
    exp_q.push_back(32'h5);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e || row_in_s !== r) begin
      n_fail++; $display("FAIL overflow_status: got %h row=%h required %h row=%h", d, row_in_s, e, r);
    end
    in_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_valid_s !== 1'b0) begin n_fail++; $display("FAIL ready_drop: got %b required 0", in_valid_s); end
    bus_wr(0, 2, 32'h4);
    exp_q.push_back(32'h0);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL overflow_w1c: got %h required %h", d, e); end
  endtask

  task automatic test_drain_irq();
    logic [31:0] d, e;
    bus_wr(0, 3, 32'h1);
    pulse_s(96'hAAAAAAAABBBBBBBBCCCCCCCC);
    @(negedge clk);
    n_tests++;
    if (irq_s !== 1'b1) begin n_fail++; $display("FAIL irq_on_capture: got %b required 1", irq_s); end
    exp_q.push_back(32'hAAAAAAAA);
    exp_q.push_back(32'hBBBBBBBB);
    exp_q.push_back(32'hCCCCCCCC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    for (int i = 0; i < 3; i++) begin
      bus_rd(0, 1, d); e = exp_q.pop_front(); n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL drain_word%0d: got %h required %h", i, d, e); end
    end
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e || irq_s !== 1'b0) begin
      n_fail++; $display("FAIL drain_done: got status=%h irq=%b required %h 0", d, irq_s, e);
    end
    bus_rd(0, 3, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL ctrl_readback: got %h required %h", d, e); end
  endtask

  task automatic test_overrun_underflow();
    logic [31:0] d, e;
    pulse_s(96'hAAAAAAAABBBBBBBBCCCCCCCC);
    pulse_s(96'h010203040506070809101112);
    exp_q.push_back(32'hA);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL overrun_status: got %h required %h", d, e); end
    exp_q.push_back(32'hAAAAAAAA);
    exp_q.push_back(32'hBBBBBBBB);
    exp_q.push_back(32'hCCCCCCCC);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_rd(0, 1, d); e = exp_q.pop_front(); n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL kept_row_word%0d: got %h required %h", i, d, e); end
    end
    exp_q.push_back(32'h18);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL underflow_status: got %h required %h", d, e); end
    bus_wr(0, 2, 32'h1C);
    exp_q.push_back(32'h0);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e || irq_s !== 1'b0) begin
      n_fail++; $display("FAIL flags_w1c: got status=%h irq=%b required %h 0", d, irq_s, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    pulse_s(96'hC0000000C1111111C2222222);
    exp_q.push_back(32'hC0000000);
    exp_q.push_back(32'hC1111111);
    exp_q.push_back(32'hC2222222);
    for (int i = 0; i < 2; i++) begin
      bus_rd(0, 1, d); e = exp_q.pop_front(); n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL b2b_word%0d: got %h required %h", i, d, e); end
    end
    @(negedge clk);
    cs_s = 1'b1; rd = 1'b1; addr = 2'd1; out_valid_s = 1'b1; row_out_s = 96'hD0000000D1111111D2222222;
    @(negedge clk);
    cs_s = 1'b0; rd = 1'b0; out_valid_s = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (rdata_s !== e) begin n_fail++; $display("FAIL b2b_last_word: got %h required %h", rdata_s, e); end
    exp_q.push_back(32'h2);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL b2b_no_overrun: got %h required %h", d, e); end
    @(negedge clk);
    cs_s = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 32'h8; out_valid_s = 1'b1; row_out_s = '1;
    @(negedge clk);
    cs_s = 1'b0; wr = 1'b0; out_valid_s = 1'b0;
    exp_q.push_back(32'hA);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL set_beats_clear: got %h required %h", d, e); end
    exp_q.push_back(32'hD0000000);
    exp_q.push_back(32'hD1111111);
    exp_q.push_back(32'hD2222222);
    for (int i = 0; i < 3; i++) begin
      bus_rd(0, 1, d); e = exp_q.pop_front(); n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL new_row_word%0d: got %h required %h", i, d, e); end
    end
    bus_wr(0, 2, 32'h8);
  endtask

  task automatic test_soft_clear_and_reset();
    logic [31:0]   d, e;
    logic [SB-1:0] r;
    in_ready = 1'b1;
    bus_wr(0, 0, 32'hDEAD0001);
    bus_wr(0, 0, 32'hDEAD0002);
    bus_rd(0, 1, d);
    exp_q.push_back(32'h0002_0010);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL partial_status: got %h required %h", d, e); end
    bus_wr(0, 3, 32'h3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL soft_clear_status: got %h required %h", d, e); end
    bus_rd(0, 3, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL soft_clear_ctrl: got %h required %h", d, e); end
    row_q.push_back(96'hF0000001F0000002F0000003);
    bus_wr(0, 0, 32'hF0000001);
    bus_wr(0, 0, 32'hF0000002);
    bus_wr(0, 0, 32'hF0000003);
    r = row_q.pop_front(); n_tests++;
    if (in_valid_s !== 1'b1 || row_in_s !== r) begin
      n_fail++; $display("FAIL fresh_row_after_clear: got %b %h required 1 %h", in_valid_s, row_in_s, r);
    end
    bus_wr(0, 0, 32'hBAD00001);
    bus_wr(0, 0, 32'hBAD00002);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_rd(0, 2, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL reset_mid_row_status: got %h required %h", d, e); end
    bus_rd(0, 3, d); e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL reset_irq_en: got %h required %h", d, e); end
    row_q.push_back(96'h0A0A0A0A0B0B0B0B0C0C0C0C);
    bus_wr(0, 0, 32'h0A0A0A0A);
    bus_wr(0, 0, 32'h0B0B0B0B);
    bus_wr(0, 0, 32'h0C0C0C0C);
    r = row_q.pop_front(); n_tests++;
    if (in_valid_s !== 1'b1 || row_in_s !== r) begin
      n_fail++; $display("FAIL fresh_row_after_reset: got %b %h required 1 %h", in_valid_s, row_in_s, r);
    end
  endtask

  task automatic test_defaults();
    logic [31:0]   d, e;
    logic [DB-1:0] tmp;
    int            early, bad;
    in_ready = 1'b1;
    early = 0;
    for (int i = 0; i < DW; i++) begin
      bus_wr(1, 0, 32'(i + 1));
      if (i < DW - 1 && in_valid_d !== 1'b0) early++;
    end
    n_tests++;
    if (early != 0 || in_valid_d !== 1'b1) begin
      n_fail++; $display("FAIL big_valid: got early=%0d valid=%b required 0 1", early, in_valid_d);
    end
    n_tests++;
    if (row_in_d[6143:6112] !== 32'h1) begin
      n_fail++; $display("FAIL big_word0: got %h required 00000001", row_in_d[6143:6112]);
    end
    bad = 0;
    for (int k = 0; k < DW; k++) begin
      tmp = row_in_d << (k * 32);
      if (tmp[DB-1 -: 32] !== 32'(k + 1)) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL big_row: got %0d wrong words required 0", bad); end
    row_out_d = row_in_d;
    @(negedge clk);
    n_tests++;
    if (in_valid_d !== 1'b0) begin n_fail++; $display("FAIL big_single_valid: got %b required 0", in_valid_d); end
    out_valid_d = 1'b1;
    @(negedge clk);
    out_valid_d = 1'b0;
    for (int i = 0; i < DW; i++) exp_q.push_back(32'(i + 1));
    for (int i = 0; i < DW; i++) begin
      bus_rd(1, 1, d); e = exp_q.pop_front(); n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL loopback_word%0d: got %h required %h", i, d, e); end
    end
  endtask

  initial begin
    cs_s = 0; cs_d = 0; wr = 0; rd = 0; addr = 0; wdata = 0;
    in_ready = 0; out_valid_s = 0; out_valid_d = 0; row_out_s = '0; row_out_d = '0;
    test_reset();
    test_fill();
    test_backpressure();
    test_drain_irq();
    test_overrun_underflow();
    test_back_to_back();
    test_soft_clear_and_reset();
    test_defaults();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/median_avalon_csr.md
Name: median_avalon_csr

Overview:
Parametrised Avalon-MM slave that sits between the host bus and the median filter core. It packs host words into a multi-line pixel row and hands the row to the filter over a valid/ready handshake. It captures the filtered row and streams it back to the host word by word. It also provides status, sticky error flags and an interrupt.

Parameters:
ROW_PIX, 256, pixels per image line
PIX_W, 8, bits per pixel
LINES, 3, image lines per filter transfer (window height)
BUS_W, 32, Avalon data width
Derived: ROW_BITS = ROW_PIX*PIX_W*LINES; WORDS = ROW_BITS/BUS_W (192 at defaults); CW = clog2(WORDS+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ChipSelect  in  1  Avalon select
Address  in  2  register index
Write  in  1  write strobe
Read  in  1  read strobe
WriteData  in  BUS_W  write data
ReadData  out  BUS_W  registered read data
irq  out  1  level interrupt
row_in  out  ROW_BITS  packed row to filter
in_valid  out  1  row_in valid
in_ready  in  1  filter accepts row
row_out  in  ROW_BITS  filtered row from filter
out_valid  in  1  one-cycle pulse, row_out valid

Behaviour:
- Register map, active only when ChipSelect=1:
  - 0 DATA_IN (W): push one word.
  - 1 DATA_OUT (R): pop one word.
  - 2 STATUS (R; W1C on bits [4:2]).
  - 3 CTRL (R/W).
- STATUS bits: [0] in_pend, [1] out_full, [2] overflow, [3] overrun, [4] underflow, [31:16] wr_cnt zero-extended; other bits 0.
- CTRL bits: [0] irq_en (R/W); [1] soft_clear (write-1, self-clearing, reads 0).
- Reset: all outputs, row_in, ReadData, counters, flags and irq_en cleared to 0.
- Input path, states FILL and PEND:
  - FILL: each DATA_IN write stores the word into the row buffer; word k occupies bits [ROW_BITS-1-k*BUS_W -: BUS_W], so the first word is most significant. wr_cnt increments.
  - The write with wr_cnt==WORDS-1 completes the row, including that word. Next cycle: row_in holds the full row, in_valid=1, wr_cnt=0, state=PEND.
  - PEND: in_valid and row_in stay stable until a cycle with in_ready=1. After that cycle, in_valid=0 and state=FILL.
  - A DATA_IN write during PEND is dropped and sets overflow.
- Output path:
  - out_valid while out_full=0: capture row_out into the output buffer; set out_full=1 and rd_idx=0.
  - out_valid while out_full=1: row is dropped and overrun is set.
- Reads:
  - Read latency is 1 cycle; ReadData holds its value between reads.
  - DATA_OUT read with out_full=1 returns word rd_idx (MS word first) and increments rd_idx. The read of word WORDS-1 clears out_full.
  - DATA_OUT read with out_full=0 returns 0 and sets underflow.
  - Any read of DATA_IN returns 0.
- irq is registered: irq = irq_en & (out_full | overflow | overrun | underflow).
- Simultaneous events:
  - W1C in the same cycle as a flag set: set wins.
  - out_valid in the same cycle as the read of the last word: new row is captured, out_full stays 1, rd_idx=0; no overrun.
- soft_clear has priority over every same-cycle event. It zeroes wr_cnt, rd_idx, in_valid, in_pend, out_full and all sticky flags. It keeps irq_en and buffer contents.
- Async reset mid-row or mid-drain discards all partial state.
- Elaboration error if ROW_BITS is not a multiple of BUS_W, or if WORDS > 65535.

Test Plan:
- Use ROW_PIX=4, LINES=3 (WORDS=3). Write 0x11111111, 0x22222222, 0x33333333 with in_ready=1 -> in_valid high exactly 1 cycle after 3rd write; row_in=0x111111112222222233333333; wr_cnt returns to 0.
- Same row with in_ready=0 for 5 cycles -> in_valid and row_in held stable; 4th DATA_IN write sets STATUS[2]. Raise in_ready -> in_valid drops the next cycle.
- Set irq_en=1, then pulse out_valid with row_out=0xAAAAAAAABBBBBBBBCCCCCCCC -> irq=1. Three DATA_OUT reads return AAAAAAAA, BBBBBBBB, CCCCCCCC; then out_full=0 and irq=0.
- Pulse out_valid twice before draining -> overrun=1, first row kept. Read DATA_OUT 4 times -> 4th read returns 0 and sets underflow. Write 0x1C to STATUS -> bits [4:2] cleared.
- Write 2 words, then write CTRL=0x2 -> wr_cnt=0. Next 3 writes form a fresh row. Repeat with rst_n pulsed low mid-row -> same result and irq_en=0.
- Defaults (WORDS=192): 192 incrementing writes -> single in_valid, word 0 at row_in[6143:6112]; loop back row_in to row_out and read 192 words -> identical sequence.
